pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipeline_controller_sat_counter.sv | 34 +++
 rtl/pipeline_controller.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_HALTED   = 3'd2,
    ST_STEP     = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  localparam int DEFAULT_MAX_MEM_WAIT = 15;
  localparam int DEFAULT_CNT_W        = 16;

  // A load in EX whose non-zero destination feeds a source operand in ID.
  function automatic logic load_use_hazard(
    input logic       mem_re,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return mem_re && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter used for the performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Increment on request, sticking at all-ones.
  always_comb begin
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush/halt controller: resolves load-use, branch, data
// memory wait and debug halt/step into stage register enables and flushes.
module pipeline_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_MEM_WAIT = DEFAULT_MAX_MEM_WAIT,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_re_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             branch_taken_E,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             idex_write_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MAX_MEM_WAIT + 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          from_step_q, from_step_d;

  logic   hazard_s;
  logic   mem_stall_s;
  logic   run_eval_s;
  logic   mem_en_s;
  logic   halt_en_s;
  state_e base_next_s;
  logic   stall_inc_s;
  logic   flush_inc_s;

  assign hazard_s    = load_use_hazard(mem_re_E, rd_E, rs1_D, rs2_D);
  assign mem_stall_s = dmem_req && !dmem_ready;

  // Next-state, wait counter and combinational stage controls.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    from_step_d   = from_step_q;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    idex_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_hold    = 1'b0;
    run_eval_s    = 1'b0;
    mem_en_s      = 1'b0;
    halt_en_s     = 1'b0;
    base_next_s   = ST_RUN;
    flush_inc_s   = 1'b0;

    if (reset) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      state_d       = ST_RUN;
      wait_d        = '0;
      from_step_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          run_eval_s  = 1'b1;
          mem_en_s    = 1'b1;
          halt_en_s   = 1'b1;
          base_next_s = ST_RUN;
        end
        ST_STEP: begin
          // The single stepped cycle must advance even though halt is held.
          run_eval_s  = 1'b1;
          mem_en_s    = 1'b1;
          halt_en_s   = 1'b0;
          base_next_s = ST_HALTED;
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_write_en = 1'b0;
            exmem_hold    = 1'b1;
            if (wait_q == WW'(MAX_MEM_WAIT - 1)) begin
              state_d = ST_ERROR;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end else begin
            // Ready cycle: behave like RUN without the memory-stall term.
            // A stall that started in STEP completes that step here.
            run_eval_s = 1'b1;
            mem_en_s   = 1'b0;
            halt_en_s  = !from_step_q;
            if (from_step_q && dbg_halt) begin
              base_next_s = ST_HALTED;
            end else begin
              base_next_s = ST_RUN;
            end
          end
        end
        ST_HALTED: begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_flush    = 1'b1;
          if (dbg_step) begin
            state_d = ST_STEP;
          end else if (!dbg_halt) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALTED;
          end
        end
        ST_ERROR: begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_write_en = 1'b0;
          exmem_hold    = 1'b1;
          state_d       = ST_ERROR;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase

      if (run_eval_s) begin
        if (mem_en_s && mem_stall_s) begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_write_en = 1'b0;
          exmem_hold    = 1'b1;
          state_d       = ST_MEM_WAIT;
          wait_d        = '0;
          from_step_d   = (state_q == ST_STEP);
        end else if (branch_taken_E) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          flush_inc_s = 1'b1;
          state_d     = base_next_s;
        end else if (hazard_s) begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_flush    = 1'b1;
          state_d       = base_next_s;
        end else if (halt_en_s && dbg_halt) begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_flush    = 1'b1;
          state_d       = ST_HALTED;
        end else begin
          state_d = base_next_s;
        end
      end else begin
        state_d = state_d;
      end
    end
  end

  // Stall cycles count only in states where the pipeline is nominally running.
  always_comb begin
    if (!reset && ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT) ||
                   (state_q == ST_STEP))) begin
      stall_inc_s = !pc_write_en;
    end else begin
      stall_inc_s = 1'b0;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      from_step_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      from_step_q <= from_step_d;
    end
  end

  assign halted = !reset && (state_q == ST_HALTED);
  assign error  = !reset && (state_q == ST_ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc_s && !reset),
    .count (flush_cnt)
  );

endmodule
